// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer.
// Holds the receiver state type, the default word width and the frame-length helper.
// Build option: PARITY_CHECK_EN appends one even-parity bit to every frame.
package sipo_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } sipo_state_e;

  localparam int unsigned DefaultWidth = 4;

  // Number of qualified bits in one frame.
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter for the SIPO deserializer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc       - one more bit of the current frame was sampled
//   restart   - this bit starts a new frame (count becomes 1); wins over inc
//   count     - bits of the current frame sampled so far
//   done      - this inc samples the last bit of the frame (count wraps to 0)
// Build option: PARITY_CHECK_EN (frame length taken from sipo_pkg::frame_len).
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam int unsigned FrameLen = frame_len(WIDTH);
  // Count never stores FrameLen itself: it wraps on the last bit, so CNT_W bits suffice.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FrameLen - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign done = inc & ~restart & (count_q == LastCnt);

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = CNT_W'(1);
    end else if (inc) begin
      count_d = done ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: assembles MSB-first bits into WIDTH-bit words and
// hands each word to the consumer with a valid/ready handshake.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   serial_in     - serial data bit, MSB first
//   shift_en      - serial_in is a valid bit this cycle
//   frame_start   - qualified bit is the first of a word
//   parallel_out  - assembled word, stable while out_valid
//   out_valid     - word available
//   out_ready     - consumer accepts the word when out_valid & out_ready
//   overrun       - sticky: a word completed while the previous one was unaccepted
//   frame_err     - one-cycle pulse per misplaced bit
//   parity_err    - sticky parity failure (PARITY_CHECK_EN builds only)
// Build option: PARITY_CHECK_EN adds a trailing even-parity bit and parity_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_err,
`ifdef PARITY_CHECK_EN
  output logic             parity_err,
`endif
  input  logic             out_ready
);

  sipo_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;
`ifdef PARITY_CHECK_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  logic             cnt_inc, cnt_restart, word_done, data_bit;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] new_word;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (cnt_inc),
    .restart (cnt_restart),
    .count   (count),
    .done    (word_done)
  );

  // Bits beyond the first WIDTH of a frame are the parity bit and are not shifted in.
  assign data_bit = (count < CNT_W'(WIDTH));
  assign new_word = data_bit ? {shift_q[WIDTH-2:0], serial_in} : shift_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a mid-word frame_start keeps us in StShift via restart.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (shift_en && frame_start) state_d = StShift;
      StShift: if (word_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and handshake next-state.
  always_comb begin
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    ferr_d      = 1'b0;
    cnt_inc     = 1'b0;
    cnt_restart = 1'b0;
`ifdef PARITY_CHECK_EN
    par_d       = par_q;
    perr_d      = perr_q;
`endif

    if (shift_en) begin
      if (frame_start) begin
        // Any partial word is discarded; this bit becomes the new MSB.
        cnt_restart = 1'b1;
        shift_d     = {{(WIDTH-1){1'b0}}, serial_in};
        ferr_d      = (state_q == StShift);
`ifdef PARITY_CHECK_EN
        par_d       = serial_in;
`endif
      end else if (state_q == StIdle) begin
        ferr_d = 1'b1;
      end else begin
        cnt_inc = 1'b1;
        if (data_bit) begin
          shift_d = {shift_q[WIDTH-2:0], serial_in};
        end
`ifdef PARITY_CHECK_EN
        par_d = par_q ^ serial_in;
`endif
      end
    end

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (word_done) begin
      if (!valid_q || out_ready) begin
        data_d  = new_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
`ifdef PARITY_CHECK_EN
      if (par_q ^ serial_in) begin
        perr_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
`ifdef PARITY_CHECK_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    parallel_out = data_q;
    out_valid    = valid_q;
    overrun      = overrun_q;
    frame_err    = ferr_q;
`ifdef PARITY_CHECK_EN
    parity_err   = perr_q;
`endif
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (WIDTH=4).
module tb_sipo_deserializer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         serial_in;
  logic         shift_en;
  logic         frame_start;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic         overrun;
  logic         frame_err;
  logic         out_ready;
`ifdef PARITY_CHECK_EN
  logic         parity_err;
`endif

  int total = 0;
  int bad   = 0;

  sipo_deserializer #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_en     (shift_en),
    .frame_start  (frame_start),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .frame_err    (frame_err),
`ifdef PARITY_CHECK_EN
    .parity_err   (parity_err),
`endif
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic cycle(input logic en, input logic fs, input logic b, input logic rdy);
    rst         = 1'b0;
    shift_en    = en;
    frame_start = fs;
    serial_in   = b;
    out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    shift_en    = 1'b0;
    frame_start = 1'b0;
    serial_in   = 1'b0;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Send one word MSB first; parity builds append the even-parity bit (optionally flipped).
  task automatic send_frame(input logic [W-1:0] w, input logic rdy, input logic flip);
    logic [W-1:0] v;
    v = w;
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b1, (i == W - 1), v[i], rdy);
    end
`ifdef PARITY_CHECK_EN
    cycle(1'b1, 1'b0, (^v) ^ flip, rdy);
`else
    if (flip) $display("note: parity flip ignored in this build");
`endif
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0 || parallel_out !== 4'b0000 || overrun !== 1'b0 ||
        frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: valid=%b data=%b ovr=%b ferr=%b, required 0 0000 0 0",
               out_valid, parallel_out, overrun, frame_err);
    end
  endtask

  task automatic test_single();
    send_frame(4'b1010, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || parallel_out !== 4'b1010) begin
      bad++;
      $display("FAIL single_word: valid=%b data=%b, required 1 1010", out_valid, parallel_out);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0 || parallel_out !== 4'b1010) begin
      bad++;
      $display("FAIL single_pulse: valid=%b data=%b, required 0 1010", out_valid, parallel_out);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(4'b1101, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || parallel_out !== 4'b1101) begin
      bad++;
      $display("FAIL b2b_first: valid=%b data=%b, required 1 1101", out_valid, parallel_out);
    end
    send_frame(4'b0110, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || parallel_out !== 4'b0110 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: valid=%b data=%b ovr=%b, required 1 0110 0",
               out_valid, parallel_out, overrun);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    send_frame(4'b1101, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || parallel_out !== 4'b1101 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL bp_first: valid=%b data=%b ovr=%b, required 1 1101 0",
               out_valid, parallel_out, overrun);
    end
    send_frame(4'b0011, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || parallel_out !== 4'b1101 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL bp_overrun: valid=%b data=%b ovr=%b, required 1 1101 1",
               out_valid, parallel_out, overrun);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0 || overrun !== 1'b1 || parallel_out !== 4'b1101) begin
      bad++;
      $display("FAIL bp_release: valid=%b ovr=%b data=%b, required 0 1 1101",
               out_valid, overrun, parallel_out);
    end
  endtask

  task automatic test_resync();
    do_reset();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_cleared: ovr=%b, required 0", overrun);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL resync_no_err: ferr=%b, required 0", frame_err);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL resync_err: ferr=%b, required 1", frame_err);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL resync_pulse: ferr=%b, required 0", frame_err);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
`ifdef PARITY_CHECK_EN
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
`endif
    total++;
    if (out_valid !== 1'b1 || parallel_out !== 4'b0101) begin
      bad++;
      $display("FAIL resync_word: valid=%b data=%b, required 1 0101", out_valid, parallel_out);
    end
    // Stray bit in idle without frame_start.
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    total++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_stray: ferr=%b valid=%b, required 1 0", frame_err, out_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL idle_stray_pulse: ferr=%b, required 0", frame_err);
    end
  endtask

  task automatic test_reset_midword();
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    do_reset();
    total++;
    if (out_valid !== 1'b0 || parallel_out !== 4'b0000) begin
      bad++;
      $display("FAIL midword_reset: valid=%b data=%b, required 0 0000", out_valid, parallel_out);
    end
    // Gaps between bits must hold state.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL gap_early: valid=%b, required 0", out_valid);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
`ifdef PARITY_CHECK_EN
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
`endif
    total++;
    if (out_valid !== 1'b1 || parallel_out !== 4'b1001) begin
      bad++;
      $display("FAIL midword_word: valid=%b data=%b, required 1 1001", out_valid, parallel_out);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    do_reset();
    send_frame(4'b1010, 1'b1, 1'b0);
    total++;
    if (parity_err !== 1'b0 || out_valid !== 1'b1 || parallel_out !== 4'b1010) begin
      bad++;
      $display("FAIL parity_good: perr=%b valid=%b data=%b, required 0 1 1010",
               parity_err, out_valid, parallel_out);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'b1010, 1'b1, 1'b1);
    total++;
    if (parity_err !== 1'b1 || out_valid !== 1'b1 || parallel_out !== 4'b1010) begin
      bad++;
      $display("FAIL parity_bad: perr=%b valid=%b data=%b, required 1 1 1010",
               parity_err, out_valid, parallel_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_resync();
    test_reset_midword();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
